// File: rtl/pkg_spi_b00.sv
// Shared definitions for the SPI mode-0 burst master: control-word field map,
// FSM state encoding and the TX byte source selection.
package pkg_spi_b00;

    localparam int SPI_BYTE_W = 8;

    localparam int SEND_BIT = 0;
    localparam int ALL1_BIT = 1;
    localparam int ALL0_BIT = 2;
    localparam int NTX_LSB  = 3;
    localparam int NTX_MSB  = 12;
    localparam int NRX_LSB  = 16;
    localparam int NRX_MSB  = 25;
    localparam int NTX_W    = NTX_MSB - NTX_LSB + 1;
    localparam int NRX_W    = NRX_MSB - NRX_LSB + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LATCH,
        SHIFT,
        STORE,
        DONE
    } state_t;

    // all_1s has priority over all_0s; otherwise the buffer byte is sent
    function automatic logic [SPI_BYTE_W-1:0] tx_select(
        input logic                  all1,
        input logic                  all0,
        input logic [SPI_BYTE_W-1:0] rd
    );
        if (all1) begin
            return '1;
        end else if (all0) begin
            return '0;
        end
        return rd;
    endfunction

endpackage

// File: rtl/module_spi_sclk_gen.sv
// SCLK generator: toggles sclk every CLK_DIV enabled cycles and flags the
// cycle whose closing edge produces a rising or falling SCLK transition.
module module_spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_reg;
    logic             sclk_reg;
    logic             tick;

    assign tick     = en && (cnt_reg == CNT_W'(CLK_DIV - 1));
    assign rise_stb = tick && !sclk_reg;
    assign fall_stb = tick && sclk_reg;
    assign sclk     = sclk_reg;

    always_ff @(posedge clk) begin
        if (srst || !en) begin
            cnt_reg  <= '0;
            sclk_reg <= 1'b0;
        end else if (tick) begin
            cnt_reg  <= '0;
            sclk_reg <= ~sclk_reg;
        end else begin
            cnt_reg  <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/module_spi_master_b00.sv
// SPI mode-0 burst master: streams n_tx_end+1 bytes from the data buffer,
// writes each received byte back in place and updates the control word.
module module_spi_master_b00 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 10,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] ctrl_i,
    output logic                  ctrl_wr_o,
    output logic [DATA_WIDTH-1:0] ctrl_o,
    output logic [ADDR_W-1:0]     data_addr_o,
    input  logic [DATA_WIDTH-1:0] data_rd_i,
    output logic                  data_wr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  sclk_o,
    output logic                  mosi_o,
    input  logic                  miso_i,
    output logic                  cs_n_o,
    output logic                  busy_o
);

    import pkg_spi_b00::*;

    state_t                  state_reg, state_next;
    logic [ADDR_W-1:0]       idx_reg, idx_next;
    logic [ADDR_W-1:0]       ntx_end_reg, ntx_end_next;
    logic [SPI_BYTE_W-1:0]   tx_reg, tx_next;
    logic [SPI_BYTE_W-1:0]   rx_reg, rx_next;
    logic [2:0]              bit_cnt_reg, bit_cnt_next;
    logic                    cs_n_reg, cs_n_next;
    logic [NRX_W-1:0]        n_rx_reg, n_rx_next;
    logic [DATA_WIDTH-1:0]   ctrl_word;
    logic                    ctrl_wr;
    logic                    data_wr;
    logic                    sclk_en;
    logic                    rise_stb;
    logic                    fall_stb;
    logic                    unused_rd_bits;

    assign unused_rd_bits = ^data_rd_i[DATA_WIDTH-1:SPI_BYTE_W];

    assign sclk_en = (state_reg == SHIFT);

    module_spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk      (clk_i),
        .srst     (rst_i),
        .en       (sclk_en),
        .sclk     (sclk_o),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            ntx_end_reg <= '0;
            tx_reg      <= '0;
            rx_reg      <= '0;
            bit_cnt_reg <= '0;
            cs_n_reg    <= 1'b1;
            n_rx_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            ntx_end_reg <= ntx_end_next;
            tx_reg      <= tx_next;
            rx_reg      <= rx_next;
            bit_cnt_reg <= bit_cnt_next;
            cs_n_reg    <= cs_n_next;
            n_rx_reg    <= n_rx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        ntx_end_next = ntx_end_reg;
        tx_next      = tx_reg;
        rx_next      = rx_reg;
        bit_cnt_next = bit_cnt_reg;
        cs_n_next    = cs_n_reg;
        n_rx_next    = n_rx_reg;
        ctrl_word    = '0;
        ctrl_wr      = 1'b0;
        data_wr      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (ctrl_i[SEND_BIT]) begin
                    state_next   = LOAD;
                    idx_next     = '0;
                    n_rx_next    = '0;
                    ntx_end_next = ADDR_W'(ctrl_i[NTX_MSB:NTX_LSB]);
                end
            end
            LOAD: begin
                // chip select drops one cycle ahead of the first MOSI bit
                cs_n_next  = 1'b0;
                state_next = LATCH;
            end
            LATCH: begin
                tx_next      = tx_select(ctrl_i[ALL1_BIT], ctrl_i[ALL0_BIT],
                                         data_rd_i[SPI_BYTE_W-1:0]);
                bit_cnt_next = '0;
                state_next   = SHIFT;
            end
            SHIFT: begin
                if (rise_stb) begin
                    rx_next = {rx_reg[SPI_BYTE_W-2:0], miso_i};
                end
                if (fall_stb) begin
                    tx_next      = {tx_reg[SPI_BYTE_W-2:0], 1'b0};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = STORE;
                    end
                end
            end
            STORE: begin
                data_wr   = 1'b1;
                ctrl_wr   = 1'b1;
                n_rx_next = NRX_W'(idx_reg + 1'b1);
                ctrl_word = ctrl_i;
                ctrl_word[NRX_MSB:NRX_LSB] = n_rx_next;
                if (idx_reg == ntx_end_reg) begin
                    cs_n_next  = 1'b1;
                    state_next = DONE;
                end else begin
                    idx_next   = idx_reg + 1'b1;
                    state_next = LOAD;
                end
            end
            DONE: begin
                ctrl_wr   = 1'b1;
                ctrl_word = ctrl_i;
                ctrl_word[NRX_MSB:NRX_LSB] = n_rx_reg;
                ctrl_word[SEND_BIT] = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ctrl_o      = ctrl_word;
    assign ctrl_wr_o   = ctrl_wr;
    assign data_wr_o   = data_wr;
    assign data_addr_o = idx_reg;
    assign data_o      = {{(DATA_WIDTH - SPI_BYTE_W){1'b0}}, rx_reg};
    assign mosi_o      = tx_reg[SPI_BYTE_W-1];
    assign cs_n_o      = cs_n_reg;
    assign busy_o      = (state_reg != IDLE);

endmodule

// File: tb/tb_module_spi_master_b00.sv
// Scoreboard bench for the SPI burst master: buffer and control-register
// models around the DUT, selectable MISO source, queued expected writes.
module tb_module_spi_master_b00;

    localparam int DW      = 32;
    localparam int AW      = 10;
    localparam int CLK_DIV = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [DW-1:0] ctrl_i;
    logic          ctrl_wr_o;
    logic [DW-1:0] ctrl_o;
    logic [AW-1:0] data_addr_o;
    logic [DW-1:0] data_rd_i;
    logic          data_wr_o;
    logic [DW-1:0] data_o;
    logic          sclk_o;
    logic          mosi_o;
    logic          miso_i;
    logic          cs_n_o;
    logic          busy_o;

    always #5 clk = ~clk;

    module_spi_master_b00 #(
        .DATA_WIDTH (DW),
        .ADDR_W     (AW),
        .CLK_DIV    (CLK_DIV)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .ctrl_i      (ctrl_i),
        .ctrl_wr_o   (ctrl_wr_o),
        .ctrl_o      (ctrl_o),
        .data_addr_o (data_addr_o),
        .data_rd_i   (data_rd_i),
        .data_wr_o   (data_wr_o),
        .data_o      (data_o),
        .sclk_o      (sclk_o),
        .mosi_o      (mosi_o),
        .miso_i      (miso_i),
        .cs_n_o      (cs_n_o),
        .busy_o      (busy_o)
    );

    // ---------------- environment models ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ctrl_reg;
    logic          ctrl_host_we;
    logic [DW-1:0] ctrl_host_d;
    logic          mem_host_we;
    logic [AW-1:0] mem_host_a;
    logic [DW-1:0] mem_host_d;
    logic [1:0]    miso_mode;
    logic [7:0]    slave_pat;
    logic [7:0]    slave_sr;
    logic          sclk_d;

    assign ctrl_i = ctrl_reg;

    always @(posedge clk) begin
        if (rst_i)             ctrl_reg <= '0;
        else if (ctrl_host_we) ctrl_reg <= ctrl_host_d;
        else if (ctrl_wr_o)    ctrl_reg <= ctrl_o;
    end

    always @(posedge clk) begin
        if (mem_host_we)    mem[mem_host_a] <= mem_host_d;
        else if (data_wr_o) mem[data_addr_o] <= data_o;
        data_rd_i <= mem[data_addr_o];
    end

    // mode-0 slave: first bit ready at CS low, next bit after each SCLK fall
    always @(posedge clk) begin
        if (cs_n_o)                 slave_sr <= slave_pat;
        else if (sclk_d && !sclk_o) slave_sr <= {slave_sr[6:0], 1'b0};
        sclk_d <= sclk_o;
    end

    // the slave source is inverted while SCLK is high to expose off-edge sampling
    always_comb begin
        case (miso_mode)
            2'd0:    miso_i = mosi_o;
            2'd1:    miso_i = 1'b0;
            default: miso_i = sclk_o ? ~slave_sr[7] : slave_sr[7];
        endcase
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    rx;
        logic [7:0]    tx;
    } dexp_t;

    dexp_t         exp_data [$];
    logic [DW-1:0] exp_ctrl [$];

    int         checks;
    int         errors;
    int         cyc;
    int         rise_in_byte;
    int         rise_total;
    int         last_rise_cyc;
    int         cs_run;
    int         last_cs_run;
    logic       sclk_prev;
    logic [7:0] mosi_cap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic host_ctrl(input logic [DW-1:0] v);
        @(negedge clk);
        ctrl_host_we = 1'b1;
        ctrl_host_d  = v;
        @(negedge clk);
        ctrl_host_we = 1'b0;
    endtask

    task automatic host_mem(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        mem_host_we = 1'b1;
        mem_host_a  = a;
        mem_host_d  = d;
        @(negedge clk);
        mem_host_we = 1'b0;
    endtask

    task automatic push_byte(input logic [AW-1:0] a, input logic [7:0] rx, input logic [7:0] tx);
        dexp_t e;
        e.addr = a;
        e.rx   = rx;
        e.tx   = tx;
        exp_data.push_back(e);
    endtask

    task automatic run_burst(input logic [DW-1:0] ctrl, input int limit, input string name);
        bit seen;
        int n;
        host_ctrl(ctrl);
        seen = 0;
        n    = 0;
        while (n < limit && !(seen && !busy_o)) begin
            @(negedge clk);
            #1;
            if (busy_o) seen = 1;
            n++;
        end
        chk({name, "_completed"}, 32'(seen && !busy_o), 32'd1);
        chk({name, "_data_queue_empty"}, 32'(exp_data.size()), 32'd0);
        chk({name, "_ctrl_queue_empty"}, 32'(exp_ctrl.size()), 32'd0);
    endtask

    initial begin
        rst_i        = 1'b1;
        ctrl_host_we = 1'b0;
        ctrl_host_d  = '0;
        mem_host_we  = 1'b0;
        mem_host_a   = '0;
        mem_host_d   = '0;
        miso_mode    = 2'd0;
        slave_pat    = 8'h00;
        checks       = 0;
        errors       = 0;
        fork
            begin : monitor
                dexp_t       e;
                logic [31:0] ce;
                cyc           = 0;
                rise_in_byte  = 0;
                rise_total    = 0;
                last_rise_cyc = 0;
                cs_run        = 0;
                last_cs_run   = 0;
                sclk_prev     = 1'b0;
                mosi_cap      = '0;
                forever begin
                    @(negedge clk);
                    cyc++;
                    if (cyc > 40000) begin
                        $display("FAIL global_timeout actual=%0d required<=40000", cyc);
                        $fatal(1, "timeout");
                    end
                    if (rst_i) begin
                        rise_in_byte = 0;
                        sclk_prev    = 1'b0;
                        cs_run       = 0;
                    end else begin
                        if (sclk_o && !sclk_prev) begin
                            if (rise_in_byte > 0)
                                chk("sclk_period", 32'(cyc - last_rise_cyc), 32'(2 * CLK_DIV));
                            last_rise_cyc = cyc;
                            rise_in_byte++;
                            rise_total++;
                            mosi_cap = {mosi_cap[6:0], mosi_o};
                        end
                        sclk_prev = sclk_o;
                        if (!cs_n_o) begin
                            cs_run++;
                        end else begin
                            if (cs_run != 0) last_cs_run = cs_run;
                            cs_run       = 0;
                            rise_in_byte = 0;
                        end
                        if (data_wr_o) begin
                            $display("data write addr=%0d data=%h mosi=%h", data_addr_o, data_o, mosi_cap);
                            if (exp_data.size() == 0) begin
                                chk("unexpected_data_wr", 32'd1, 32'd0);
                            end else begin
                                e = exp_data.pop_front();
                                chk("data_addr", 32'(data_addr_o), 32'(e.addr));
                                chk("data_word", data_o, {24'b0, e.rx});
                                chk("mosi_byte", 32'(mosi_cap), 32'(e.tx));
                                chk("rises_per_byte", 32'(rise_in_byte), 32'd8);
                            end
                            rise_in_byte = 0;
                        end
                        if (ctrl_wr_o) begin
                            $display("ctrl write word=%h", ctrl_o);
                            if (exp_ctrl.size() == 0) begin
                                chk("unexpected_ctrl_wr", 32'd1, 32'd0);
                            end else begin
                                ce = exp_ctrl.pop_front();
                                chk("ctrl_word", ctrl_o, ce);
                            end
                        end
                    end
                end
            end
            begin : stimulus
                int base;
                int n;
                bit busy_seen;
                repeat (3) @(posedge clk);
                @(negedge clk);
                rst_i = 1'b0;
                @(negedge clk);
                #1;
                chk("rst_cs_n", 32'(cs_n_o), 32'd1);
                chk("rst_sclk", 32'(sclk_o), 32'd0);
                chk("rst_mosi", 32'(mosi_o), 32'd0);
                chk("rst_strobes", 32'({ctrl_wr_o, data_wr_o}), 32'd0);
                chk("rst_busy", 32'(busy_o), 32'd0);
                chk("rst_addr", 32'(data_addr_o), 32'd0);
                chk("rst_data_o", data_o, 32'd0);
                chk("rst_ctrl_o", ctrl_o, 32'd0);

                // 1: loopback burst of four bytes, pass-through bits 31 and 14
                host_mem(10'd0, 32'h0000_00A5);
                host_mem(10'd1, 32'h0000_003C);
                host_mem(10'd2, 32'h0000_00FF);
                host_mem(10'd3, 32'h0000_0001);
                miso_mode = 2'd0;
                push_byte(10'd0, 8'hA5, 8'hA5);
                push_byte(10'd1, 8'h3C, 8'h3C);
                push_byte(10'd2, 8'hFF, 8'hFF);
                push_byte(10'd3, 8'h01, 8'h01);
                exp_ctrl.push_back(32'h8001_4019);
                exp_ctrl.push_back(32'h8002_4019);
                exp_ctrl.push_back(32'h8003_4019);
                exp_ctrl.push_back(32'h8004_4019);
                exp_ctrl.push_back(32'h8004_4018);
                run_burst(32'h8000_4019, 2000, "t1");
                chk("t1_cs_low_cycles", 32'(last_cs_run), 32'd267);
                chk("t1_buf0", mem[0], 32'h0000_00A5);
                chk("t1_buf1", mem[1], 32'h0000_003C);
                chk("t1_buf2", mem[2], 32'h0000_00FF);
                chk("t1_buf3", mem[3], 32'h0000_0001);
                chk("t1_ctrl_reg", ctrl_reg, 32'h8004_4018);

                // 6: control register loops back send=0, so no further burst
                busy_seen = 0;
                for (int i = 0; i < 60; i++) begin
                    @(negedge clk);
                    if (busy_o) busy_seen = 1;
                end
                chk("t6_no_restart", 32'(busy_seen), 32'd0);

                // 2: all_1s, single byte, miso held low
                host_mem(10'd0, 32'h0000_005A);
                miso_mode = 2'd1;
                push_byte(10'd0, 8'h00, 8'hFF);
                exp_ctrl.push_back(32'h0001_0003);
                exp_ctrl.push_back(32'h0001_0002);
                run_burst(32'h0000_0003, 500, "t2");
                chk("t2_buf0", mem[0], 32'h0000_0000);

                // 3: all_1s and all_0s together, loopback
                host_mem(10'd0, 32'h0000_0012);
                miso_mode = 2'd0;
                push_byte(10'd0, 8'hFF, 8'hFF);
                exp_ctrl.push_back(32'h0001_0007);
                exp_ctrl.push_back(32'h0001_0006);
                run_burst(32'h0000_0007, 500, "t3");

                // 4: slave returns C3 with mode-0 timing
                host_mem(10'd0, 32'h0000_0000);
                slave_pat = 8'hC3;
                miso_mode = 2'd2;
                push_byte(10'd0, 8'hC3, 8'h00);
                exp_ctrl.push_back(32'h0001_0001);
                exp_ctrl.push_back(32'h0001_0000);
                run_burst(32'h0000_0001, 500, "t4");
                chk("t4_buf0", mem[0], 32'h0000_00C3);

                // 5: reset at the 5th rise of the second byte of a 3-byte burst
                host_mem(10'd0, 32'h0000_0011);
                host_mem(10'd1, 32'h0000_0022);
                host_mem(10'd2, 32'h0000_0033);
                miso_mode = 2'd0;
                push_byte(10'd0, 8'h11, 8'h11);
                exp_ctrl.push_back(32'h0001_0011);
                base = rise_total;
                host_ctrl(32'h0000_0011);
                n = 0;
                while (rise_total < base + 13 && n < 2000) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                chk("t5_rise_reached", 32'(rise_total - base), 32'd13);
                rst_i = 1'b1;
                @(negedge clk);
                #1;
                chk("t5_cs_n_after_rst", 32'(cs_n_o), 32'd1);
                chk("t5_sclk_after_rst", 32'(sclk_o), 32'd0);
                chk("t5_busy_after_rst", 32'(busy_o), 32'd0);
                rst_i = 1'b0;
                busy_seen = 0;
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (busy_o) busy_seen = 1;
                end
                chk("t5_stays_idle", 32'(busy_seen), 32'd0);
                chk("t5_data_queue_empty", 32'(exp_data.size()), 32'd0);
                chk("t5_ctrl_queue_empty", 32'(exp_ctrl.size()), 32'd0);

                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        join_any
    end

endmodule
